// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: fetches one byte per frame from a show-ahead-free
// FIFO read port and shifts it out as 8 data bits, LSB first, with 1 or 2 stop bits.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dout,
  output logic        fifo_rd,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] byte_cnt
);

  localparam int              BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t        state_r, state_s;
  logic [BW-1:0] baud_r, baud_s;
  logic [2:0]    bit_r, bit_s;
  logic [7:0]    shreg_r, shreg_s;
  logic          baud_last_s;
  logic          tx_s, rd_s, busy_s, done_s;

  assign baud_last_s = (baud_r == BAUD_LAST);

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      baud_r     <= '0;
      bit_r      <= 3'd0;
      shreg_r    <= 8'd0;
      tx         <= 1'b1;
      fifo_rd    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      byte_cnt   <= 16'd0;
    end else begin
      state_r    <= state_s;
      baud_r     <= baud_s;
      bit_r      <= bit_s;
      shreg_r    <= shreg_s;
      tx         <= tx_s;
      fifo_rd    <= rd_s;
      busy       <= busy_s;
      frame_done <= done_s;
      if (frame_done) begin
        byte_cnt <= byte_cnt + 16'd1;
      end else begin
        byte_cnt <= byte_cnt;
      end
    end
  end

  // Next-state decode; en and fifo_empty only matter while idle
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (en && !fifo_empty) state_s = FETCH;
        else                   state_s = IDLE;
      end
      FETCH: state_s = LOAD;
      LOAD:  state_s = START;
      START: begin
        if (baud_last_s) state_s = DATA;
        else             state_s = START;
      end
      DATA: begin
        if (baud_last_s && (bit_r == 3'd7)) state_s = DATA == DATA ? STOP : STOP;
        else                                state_s = DATA;
      end
      STOP: begin
        if (baud_last_s && (bit_r == STOP_LAST)) state_s = IDLE;
        else                                     state_s = STOP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Counter/shift updates and output values for the upcoming cycle, so every output is a flop
  always_comb begin
    baud_s  = '0;
    bit_s   = 3'd0;
    shreg_s = shreg_r;
    tx_s    = 1'b1;
    if (state_s != state_r) begin
      baud_s = '0;
      bit_s  = 3'd0;
    end else if (baud_last_s) begin
      baud_s = '0;
      bit_s  = bit_r + 3'd1;
    end else begin
      baud_s = baud_r + BW'(1);
      bit_s  = bit_r;
    end
    if (state_r == LOAD) begin
      shreg_s = fifo_dout;
    end else begin
      shreg_s = shreg_r;
    end
    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shreg_s[bit_s];
      default: tx_s = 1'b1;
    endcase
    rd_s   = (state_s == FETCH);
    busy_s = (state_s != IDLE);
    done_s = (state_s == STOP) && (baud_s == BAUD_LAST) && (bit_s == STOP_LAST);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed + randomized bench for fifo_uart_tx: a FIFO model feeds the DUT and each
// frame is compared cycle by cycle against the bit pattern computed from the byte.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        fifo_empty, fifo_rd, tx, busy, frame_done;
  logic [7:0]  fifo_dout = 8'h00;
  logic [15:0] byte_cnt;

  logic        en2 = 1'b1;
  logic        fifo_empty2, fifo_rd2, tx2, busy2, frame_done2;
  logic [7:0]  fifo_dout2 = 8'h00;
  logic [15:0] byte_cnt2;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .frame_done(frame_done), .byte_cnt(byte_cnt)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .fifo_empty(fifo_empty2), .fifo_dout(fifo_dout2),
    .fifo_rd(fifo_rd2), .tx(tx2), .busy(busy2), .frame_done(frame_done2), .byte_cnt(byte_cnt2)
  );

  // FIFO models: read data updates on the same edge that accepts rd
  logic [7:0] mem [0:63];
  logic [5:0] wp = 6'd0, rp = 6'd0;
  logic [7:0] mem2 [0:3];
  logic [1:0] wp2 = 2'd0, rp2 = 2'd0;
  assign fifo_empty  = (wp == rp);
  assign fifo_empty2 = (wp2 == rp2);

  always @(posedge clk) begin
    if (fifo_rd && (wp != rp)) begin
      fifo_dout <= mem[rp];
      rp        <= rp + 6'd1;
    end
    if (fifo_rd2 && (wp2 != rp2)) begin
      fifo_dout2 <= mem2[rp2];
      rp2        <= rp2 + 2'd1;
    end
  end

  int   rd_pulses = 0, done_pulses = 0, bad_rd = 0;
  logic rd_prev = 1'b0;
  always @(posedge clk) begin
    rd_prev <= fifo_rd;
    if (fifo_rd) rd_pulses <= rd_pulses + 1;
    if (frame_done) done_pulses <= done_pulses + 1;
    if (fifo_rd && (rd_prev || fifo_empty)) bad_rd <= bad_rd + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp] = b;
    wp = wp + 6'd1;
  endtask

  // Waits (bounded) for the start bit, then checks every cycle of the frame
  task automatic expect_frame(input bit sel, input logic [7:0] b, input int stop_bits,
                              input int drop_at, output int gap);
    int   n;
    int   total;
    logic bitv, txv, donev;
    n   = 0;
    txv = sel ? tx2 : tx;
    while (txv !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
      txv = sel ? tx2 : tx;
    end
    gap = n;
    check("start_seen", 32'(n < 300), 32'd1);
    total = (9 + stop_bits) * CPB;
    for (int k = 0; k < total; k++) begin
      int bi = k / CPB;
      if (bi == 0)      bitv = 1'b0;
      else if (bi <= 8) bitv = b[bi-1];
      else              bitv = 1'b1;
      if (k == drop_at) en = 1'b0;
      txv   = sel ? tx2 : tx;
      donev = sel ? frame_done2 : frame_done;
      check($sformatf("tx_%0h_c%0d", b, k), 32'(txv), 32'(bitv));
      check($sformatf("frame_done_c%0d", k), 32'(donev), 32'(k == total - 1));
      @(negedge clk);
    end
  endtask

  initial begin
    int         gap, rd0, d0, n;
    logic [7:0] bytes [0:3];
    logic [7:0] x, y, z;

    rst = 1'b0;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'({tx, fifo_rd, busy, frame_done, byte_cnt}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 16'd0}));
    rst = 1'b1;
    en  = 1'b1;

    // Idle with empty FIFO
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_empty", 32'({tx, fifo_rd, busy, byte_cnt}), 32'({1'b1, 1'b0, 1'b0, 16'd0}));
    end

    // Single byte 0xA5, including fetch latency
    rd0 = rd_pulses;
    d0  = done_pulses;
    push(8'hA5);
    @(negedge clk);
    check("latency_rd", 32'(fifo_rd), 32'd1);
    @(negedge clk);
    check("latency_load", 32'({fifo_rd, busy, tx}), 32'(3'b011));
    @(negedge clk);
    expect_frame(1'b0, 8'hA5, 1, -1, gap);
    check("latency_start", 32'(gap), 32'd0);
    exp_cnt++;
    check("a5_rd_pulses", 32'(rd_pulses - rd0), 32'd1);
    check("a5_done_pulses", 32'(done_pulses - d0), 32'd1);
    check("a5_byte_cnt", 32'(byte_cnt), 32'(exp_cnt));

    // Back-to-back: 0x00, 0xFF, 0x3C
    rd0 = rd_pulses;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
    for (int i = 0; i < 3; i++) push(bytes[i]);
    for (int i = 0; i < 3; i++) begin
      expect_frame(1'b0, bytes[i], 1, -1, gap);
      check("b2b_gap", 32'(gap), 32'd3);
      exp_cnt++;
    end
    repeat (10) begin
      check("drained_idle", 32'({fifo_rd, busy, tx}), 32'(3'b001));
      @(negedge clk);
    end
    check("b2b_rd_pulses", 32'(rd_pulses - rd0), 32'd3);
    check("b2b_byte_cnt", 32'(byte_cnt), 32'(exp_cnt));

    // Random back-to-back bytes
    for (int i = 0; i < 4; i++) begin
      bytes[i] = 8'($urandom);
      push(bytes[i]);
    end
    for (int i = 0; i < 4; i++) begin
      expect_frame(1'b0, bytes[i], 1, -1, gap);
      check("rand_gap", 32'(gap), 32'd3);
      exp_cnt++;
    end
    check("rand_byte_cnt", 32'(byte_cnt), 32'(exp_cnt));

    // en dropped during DATA of a frame with a second byte queued
    rd0 = rd_pulses;
    x = 8'($urandom);
    y = 8'($urandom);
    push(x);
    push(y);
    expect_frame(1'b0, x, 1, CPB * 4 + 1, gap);
    exp_cnt++;
    for (int i = 0; i < 30; i++) begin
      check("en_off_idle", 32'({fifo_rd, busy, tx}), 32'(3'b001));
      @(negedge clk);
    end
    check("en_off_rd_pulses", 32'(rd_pulses - rd0), 32'd1);
    check("en_off_byte_cnt", 32'(byte_cnt), 32'(exp_cnt));

    // Reset in the middle of data bit 3; the queued byte after it goes out whole
    z = 8'($urandom);
    push(z);
    en = 1'b1;
    n  = 0;
    while (tx !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rst_frame_start", 32'(n < 300), 32'd1);
    repeat (CPB * 4 + 2) @(negedge clk);
    check("rst_pre_bit3", 32'(tx), 32'(y[3]));
    #2 rst = 1'b0;
    #1;
    check("rst_async", 32'({tx, busy, fifo_rd, frame_done, byte_cnt}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 16'd0}));
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    expect_frame(1'b0, z, 1, -1, gap);
    exp_cnt++;
    check("rst_resume_byte_cnt", 32'(byte_cnt), 32'(exp_cnt));

    // Two stop bits on the second instance
    mem2[wp2] = 8'h81;
    wp2 = wp2 + 2'd1;
    expect_frame(1'b1, 8'h81, 2, -1, gap);
    check("stop2_byte_cnt", 32'(byte_cnt2), 32'd1);
    check("stop2_idle", 32'({busy2, tx2}), 32'(2'b01));

    check("rd_protocol", 32'(bad_rd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
